// File: rtl/stream_split_buffered_if.sv
// Valid/ready stream carrying a W-bit payload.
interface std_stream_intf #(
  parameter int unsigned W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] payload;

  // Consumer side of the stream
  modport in (
    input  valid,
    input  payload,
    output ready
  );

  // Producer side of the stream
  modport out (
    output valid,
    output payload,
    input  ready
  );

  // Aliases for the producer/consumer view
  modport master (
    output valid,
    output payload,
    input  ready
  );

  modport slave (
    input  valid,
    input  payload,
    output ready
  );
endinterface

// File: rtl/stream_split_buffered.sv
// 1-to-PORTS stream demultiplexer with a DEPTH-entry FIFO per output port,
// optional multicast by mask, and a saturating counter for unroutable beats.
module stream_split_buffered #(
  parameter int unsigned PORTS            = 2,
  parameter int unsigned ID_WIDTH         = $clog2(PORTS),
  parameter int unsigned DEPTH            = 2,
  parameter int unsigned MULTICAST        = 0,
  parameter int unsigned DROP_COUNT_WIDTH = 16,
  parameter int unsigned LEVEL_WIDTH      = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  std_stream_intf.in                  stream_in,
  input  logic [ID_WIDTH-1:0]         stream_in_id,
  input  logic [PORTS-1:0]            stream_in_mask,
  std_stream_intf.out                 stream_out [PORTS],
  output logic [ID_WIDTH-1:0]         stream_out_id [PORTS],
  output logic [LEVEL_WIDTH-1:0]      port_level [PORTS],
  output logic [DROP_COUNT_WIDTH-1:0] drop_count,
  output logic                        drop_pulse
);

  localparam int unsigned W  = $bits(stream_in.payload);
  localparam int unsigned PW = $clog2(DEPTH);

  // Elaboration-time parameter checks
  if (PORTS < 2) begin : g_bad_ports
    $error("stream_split_buffered: PORTS must be greater than 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("stream_split_buffered: DEPTH must be a power of two >= 2");
  end

  logic [PORTS-1:0] ts;
  logic [PORTS-1:0] full;
  logic             rdy_c;
  logic             accept;
  logic             drop;

  // Target set: one-hot of the id (out-of-range ids give an empty set) or the mask
  if (MULTICAST != 0) begin : g_ts_mask
    logic unused_id;
    assign unused_id = ^stream_in_id;
    assign ts        = stream_in_mask;

    a_mask_known : assert property (@(posedge clk) disable iff (rst)
      stream_in.valid |-> !$isunknown(stream_in_mask));
  end else begin : g_ts_id
    logic unused_mask;
    assign unused_mask = ^stream_in_mask;

    // Decode the id against every port index
    always_comb begin
      ts = '0;
      for (int unsigned k = 0; k < PORTS; k++) begin
        ts[k] = (32'(stream_in_id) == 32'(k));
      end
    end

    a_id_known : assert property (@(posedge clk) disable iff (rst)
      stream_in.valid |-> !$isunknown(stream_in_id));
  end

  // Ready only when every targeted FIFO has room; independent of valid
  always_comb begin
    rdy_c = !rst;
    for (int unsigned k = 0; k < PORTS; k++) begin
      if (ts[k] && full[k]) begin
        rdy_c = 1'b0;
      end
    end
  end

  assign stream_in.ready = rdy_c;
  assign accept          = stream_in.valid && rdy_c;
  assign drop            = accept && (ts == '0);

  // Count discarded beats (saturating) and flag each one for a cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + DROP_COUNT_WIDTH'(1);
      end
    end
  end

  // Per-port FIFO; pointers carry one extra bit to tell full from empty
  for (genvar k = 0; k < PORTS; k++) begin : g_port
    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         push;
    logic         pop;
    logic         empty;

    if ($bits(stream_out[k].payload) != W) begin : g_bad_width
      $error("stream_split_buffered: output payload width differs from input");
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full[k]  = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign push     = accept && ts[k];
    assign pop      = !empty && stream_out[k].ready;

    assign stream_out[k].valid   = !empty;
    assign stream_out[k].payload = mem[rd_ptr[PW-1:0]];
    assign stream_out_id[k]      = ID_WIDTH'(k);

    // Pointer and occupancy update
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        port_level[k] <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + (PW + 1)'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + (PW + 1)'(1);
        end
        case ({push, pop})
          2'b10:   port_level[k] <= port_level[k] + LEVEL_WIDTH'(1);
          2'b01:   port_level[k] <= port_level[k] - LEVEL_WIDTH'(1);
          default: port_level[k] <= port_level[k];
        endcase
      end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr[PW-1:0]] <= stream_in.payload;
      end
    end
  end

endmodule

// File: tb/tb_stream_split_buffered.sv
// Directed bench for stream_split_buffered: unicast, multicast and drop configs.
module tb_stream_split_buffered;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT a: PORTS=4, unicast ----------------
  std_stream_intf #(.W(8)) a_in ();
  std_stream_intf #(.W(8)) a_out [4] ();
  logic [1:0]  a_id;
  logic [3:0]  a_mask;
  logic [1:0]  a_oid [4];
  logic [1:0]  a_lvl [4];
  logic [15:0] a_dc;
  logic        a_dp;
  logic [3:0]  a_ov;
  logic [3:0]  a_ordy;
  logic [7:0]  a_op [4];
  logic [7:0]  a_lvl_pk;
  logic [7:0]  a_oid_pk;

  stream_split_buffered #(.PORTS(4), .DEPTH(2), .MULTICAST(0)) u_a (
    .clk(clk), .rst(rst), .stream_in(a_in), .stream_in_id(a_id),
    .stream_in_mask(a_mask), .stream_out(a_out), .stream_out_id(a_oid),
    .port_level(a_lvl), .drop_count(a_dc), .drop_pulse(a_dp));

  for (genvar k = 0; k < 4; k++) begin : g_a
    assign a_ov[k]         = a_out[k].valid;
    assign a_op[k]         = a_out[k].payload;
    assign a_out[k].ready  = a_ordy[k];
  end
  assign a_lvl_pk = {a_lvl[3], a_lvl[2], a_lvl[1], a_lvl[0]};
  assign a_oid_pk = {a_oid[3], a_oid[2], a_oid[1], a_oid[0]};

  // ---------------- DUT b: PORTS=4, multicast ----------------
  std_stream_intf #(.W(8)) b_in ();
  std_stream_intf #(.W(8)) b_out [4] ();
  logic [1:0]  b_id;
  logic [3:0]  b_mask;
  logic [1:0]  b_oid [4];
  logic [1:0]  b_lvl [4];
  logic [15:0] b_dc;
  logic        b_dp;
  logic [3:0]  b_ov;
  logic [3:0]  b_ordy;
  logic [7:0]  b_op [4];
  logic [7:0]  b_lvl_pk;

  stream_split_buffered #(.PORTS(4), .DEPTH(2), .MULTICAST(1)) u_b (
    .clk(clk), .rst(rst), .stream_in(b_in), .stream_in_id(b_id),
    .stream_in_mask(b_mask), .stream_out(b_out), .stream_out_id(b_oid),
    .port_level(b_lvl), .drop_count(b_dc), .drop_pulse(b_dp));

  for (genvar k = 0; k < 4; k++) begin : g_b
    assign b_ov[k]        = b_out[k].valid;
    assign b_op[k]        = b_out[k].payload;
    assign b_out[k].ready = b_ordy[k];
  end
  assign b_lvl_pk = {b_lvl[3], b_lvl[2], b_lvl[1], b_lvl[0]};

  // ---------------- DUT c: PORTS=3, 2-bit drop counter ----------------
  std_stream_intf #(.W(8)) c_in ();
  std_stream_intf #(.W(8)) c_out [3] ();
  logic [1:0] c_id;
  logic [2:0] c_mask;
  logic [1:0] c_oid [3];
  logic [1:0] c_lvl [3];
  logic [1:0] c_dc;
  logic       c_dp;
  logic [2:0] c_ov;
  logic [2:0] c_ordy;
  logic [7:0] c_op [3];

  stream_split_buffered #(.PORTS(3), .DEPTH(2), .MULTICAST(0),
                          .DROP_COUNT_WIDTH(2)) u_c (
    .clk(clk), .rst(rst), .stream_in(c_in), .stream_in_id(c_id),
    .stream_in_mask(c_mask), .stream_out(c_out), .stream_out_id(c_oid),
    .port_level(c_lvl), .drop_count(c_dc), .drop_pulse(c_dp));

  for (genvar k = 0; k < 3; k++) begin : g_c
    assign c_ov[k]        = c_out[k].valid;
    assign c_op[k]        = c_out[k].payload;
    assign c_out[k].ready = c_ordy[k];
  end

  // ---------------- checking ----------------
  int nvec;
  int nerr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       vld;
    logic [1:0] id;
    logic [7:0] pay;
    logic [3:0] ordy;
    logic       e_rdy;
    logic [3:0] e_ov;
    int         e_port;
    logic [7:0] e_pay;
    logic [7:0] e_lvl;
  } vec_t;

  function automatic vec_t mk(logic vld, logic [1:0] id, logic [7:0] pay,
                              logic [3:0] ordy, logic e_rdy, logic [3:0] e_ov,
                              int e_port, logic [7:0] e_pay, logic [7:0] e_lvl);
    vec_t v;
    v.vld = vld; v.id = id; v.pay = pay; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_port = e_port;
    v.e_pay = e_pay; v.e_lvl = e_lvl;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    nvec = 0;
    nerr = 0;

    // Unicast, all consumers ready: one beat per cycle, each on its own port
    tbl.push_back(mk(1, 0, 8'hA0, 4'hF, 1, 4'h0, -1, 8'h00, 8'h00));
    tbl.push_back(mk(1, 1, 8'hA1, 4'hF, 1, 4'h1,  0, 8'hA0, 8'h01));
    tbl.push_back(mk(1, 2, 8'hA2, 4'hF, 1, 4'h2,  1, 8'hA1, 8'h04));
    tbl.push_back(mk(1, 3, 8'hA3, 4'hF, 1, 4'h4,  2, 8'hA2, 8'h10));
    tbl.push_back(mk(1, 0, 8'hA4, 4'hF, 1, 4'h8,  3, 8'hA3, 8'h40));
    tbl.push_back(mk(0, 0, 8'h00, 4'hF, 1, 4'h1,  0, 8'hA4, 8'h01));
    tbl.push_back(mk(0, 0, 8'h00, 4'hF, 1, 4'h0, -1, 8'h00, 8'h00));
    // Port 1 stalled: fills, blocks input, then drains in order
    tbl.push_back(mk(1, 1, 8'hB0, 4'hD, 1, 4'h0, -1, 8'h00, 8'h00));
    tbl.push_back(mk(1, 1, 8'hB1, 4'hD, 1, 4'h2,  1, 8'hB0, 8'h04));
    tbl.push_back(mk(1, 1, 8'hB2, 4'hD, 0, 4'h2,  1, 8'hB0, 8'h08));
    tbl.push_back(mk(1, 1, 8'hB2, 4'hD, 0, 4'h2,  1, 8'hB0, 8'h08));
    tbl.push_back(mk(1, 1, 8'hB2, 4'hF, 0, 4'h2,  1, 8'hB0, 8'h08));
    tbl.push_back(mk(1, 1, 8'hB2, 4'hF, 1, 4'h2,  1, 8'hB1, 8'h04));
    tbl.push_back(mk(1, 2, 8'hC0, 4'hF, 1, 4'h2,  1, 8'hB2, 8'h04));
    tbl.push_back(mk(0, 0, 8'h00, 4'hF, 1, 4'h4,  2, 8'hC0, 8'h10));
    tbl.push_back(mk(0, 0, 8'h00, 4'hF, 1, 4'h0, -1, 8'h00, 8'h00));
    // Port 1 stalled, port 2 keeps flowing
    tbl.push_back(mk(1, 1, 8'hD0, 4'hD, 1, 4'h0, -1, 8'h00, 8'h00));
    tbl.push_back(mk(1, 2, 8'hD1, 4'hD, 1, 4'h2,  1, 8'hD0, 8'h04));
    tbl.push_back(mk(1, 2, 8'hD2, 4'hD, 1, 4'h6,  2, 8'hD1, 8'h14));
    tbl.push_back(mk(1, 2, 8'hD3, 4'hD, 1, 4'h6,  2, 8'hD2, 8'h14));
    tbl.push_back(mk(0, 0, 8'h00, 4'hD, 1, 4'h6,  2, 8'hD3, 8'h14));
    tbl.push_back(mk(0, 0, 8'h00, 4'hD, 1, 4'h2,  1, 8'hD0, 8'h04));
    tbl.push_back(mk(0, 0, 8'h00, 4'hF, 1, 4'h2,  1, 8'hD0, 8'h04));
    tbl.push_back(mk(0, 0, 8'h00, 4'hF, 1, 4'h0, -1, 8'h00, 8'h00));

    rst = 1'b1;
    a_in.valid = 1'b0; a_in.payload = '0; a_id = '0; a_mask = '0; a_ordy = 4'hF;
    b_in.valid = 1'b0; b_in.payload = '0; b_id = '0; b_mask = '0; b_ordy = 4'hF;
    c_in.valid = 1'b0; c_in.payload = '0; c_id = '0; c_mask = '0; c_ordy = 3'h7;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_a_ready", 32'(a_in.ready), 32'd0);
    chk("rst_a_valid", 32'(a_ov), 32'd0);
    chk("rst_a_level", 32'(a_lvl_pk), 32'd0);
    chk("rst_a_dcount", 32'(a_dc), 32'd0);
    chk("rst_a_dpulse", 32'(a_dp), 32'd0);
    chk("rst_b_valid", 32'(b_ov), 32'd0);
    chk("rst_c_dcount", 32'(c_dc), 32'd0);
    chk("out_id", 32'(a_oid_pk), 32'hE4);
    rst = 1'b0;

    // Table-driven unicast sequences on DUT a
    for (int i = 0; i < tbl.size(); i++) begin
      a_in.valid   = tbl[i].vld;
      a_id         = tbl[i].id;
      a_in.payload = tbl[i].pay;
      a_ordy       = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(a_in.ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_valid", i), 32'(a_ov), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_level", i), 32'(a_lvl_pk), 32'(tbl[i].e_lvl));
      if (tbl[i].e_port >= 0) begin
        chk($sformatf("v%0d_payload", i), 32'(a_op[tbl[i].e_port]), 32'(tbl[i].e_pay));
      end
      @(negedge clk);
    end
    a_in.valid = 1'b0;

    // Multicast: port 3 full blocks the whole beat, then one atomic accept
    b_ordy = 4'b0111;
    b_in.valid = 1'b1; b_mask = 4'b1000; b_in.payload = 8'hE0;
    #1 chk("mc_e0_ready", 32'(b_in.ready), 32'd1);
    @(negedge clk);
    b_in.payload = 8'hE1;
    #1 chk("mc_e1_ready", 32'(b_in.ready), 32'd1);
    @(negedge clk);
    b_mask = 4'b1011; b_in.payload = 8'hF0;
    #1;
    chk("mc_full_ready", 32'(b_in.ready), 32'd0);
    chk("mc_full_level", 32'(b_lvl_pk), 32'h80);
    @(negedge clk);
    #1;
    chk("mc_no_partial", 32'(b_ov), 32'h8);
    chk("mc_no_partial_lvl", 32'(b_lvl_pk), 32'h80);
    b_ordy = 4'hF;
    #1 chk("mc_no_bypass", 32'(b_in.ready), 32'd0);
    @(negedge clk);
    #1;
    chk("mc_freed_ready", 32'(b_in.ready), 32'd1);
    chk("mc_p3_head", 32'(b_op[3]), 32'hE1);
    @(negedge clk);
    b_in.valid = 1'b0;
    #1;
    chk("mc_valid", 32'(b_ov), 32'hB);
    chk("mc_p0", 32'(b_op[0]), 32'hF0);
    chk("mc_p1", 32'(b_op[1]), 32'hF0);
    chk("mc_p3", 32'(b_op[3]), 32'hF0);
    chk("mc_level", 32'(b_lvl_pk), 32'h45);
    @(negedge clk);
    #1 chk("mc_empty", 32'(b_ov), 32'h0);

    // Drops: out-of-range id is accepted and counted, counter saturates
    c_in.valid = 1'b1; c_id = 2'd3; c_in.payload = 8'h55;
    #1 chk("drop_ready", 32'(c_in.ready), 32'd1);
    @(negedge clk);
    c_in.valid = 1'b0;
    #1;
    chk("drop_pulse_hi", 32'(c_dp), 32'd1);
    chk("drop_count1", 32'(c_dc), 32'd1);
    chk("drop_no_out", 32'(c_ov), 32'd0);
    @(negedge clk);
    #1;
    chk("drop_pulse_lo", 32'(c_dp), 32'd0);
    chk("drop_count_hold", 32'(c_dc), 32'd1);
    c_in.valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk($sformatf("drop_sat%0d", i), 32'(c_dc), (i + 2 > 3) ? 32'd3 : 32'(i + 2));
    end
    c_in.valid = 1'b0;
    chk("drop_pulse_run", 32'(c_dp), 32'd1);

    // Reset mid-operation discards buffered beats
    @(negedge clk);
    a_ordy = 4'b1110;
    a_in.valid = 1'b1; a_id = 2'd0; a_in.payload = 8'h60;
    @(negedge clk);
    a_in.payload = 8'h61;
    @(negedge clk);
    a_in.valid = 1'b0;
    #1;
    chk("mid_level_p0", 32'(a_lvl[0]), 32'd2);
    chk("mid_valid", 32'(a_ov), 32'h1);
    rst = 1'b1; a_id = 2'd2;
    #1 chk("mid_rst_ready", 32'(a_in.ready), 32'd0);
    @(negedge clk);
    #1;
    chk("post_rst_valid", 32'(a_ov), 32'h0);
    chk("post_rst_level", 32'(a_lvl_pk), 32'h0);
    rst = 1'b0;
    a_ordy = 4'hF;
    a_in.valid = 1'b1; a_id = 2'd0; a_in.payload = 8'h70;
    @(negedge clk);
    a_in.valid = 1'b0;
    #1;
    chk("post_rst_first_valid", 32'(a_ov), 32'h1);
    chk("post_rst_first_pay", 32'(a_op[0]), 32'h70);
    chk("post_rst_first_lvl", 32'(a_lvl_pk), 32'h01);
    @(negedge clk);
    #1 chk("post_rst_drained", 32'(a_ov), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
